demux_1_n_stream: RTL and testbench
===================================

DEMUX_1_N_STREAM -- requirements
Module: demux_1_n_stream

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits (legal 1..64).
REQ-002 Parameter N_OUT, default 8: output channel count (legal 2..32, need not be a power of 2).
REQ-003 Parameter SEL_W, derived as ceil(log2(N_OUT)): select width, not user-overridden.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  input payload.
- s_sel  in  SEL_W  destination channel.
- s_bcast  in  1  1 = deliver beat to all channels.
- m_valid  out  N_OUT  per-channel output valid.
- m_ready  in  N_OUT  per-channel output ready.
- m_data  out  N_OUT*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- drop_cnt  out  16  count of beats with out-of-range s_sel.

Function
REQ-005 Each channel SHALL hold a one-entry output register; channel i is free when !m_valid[i] || m_ready[i].
REQ-006 Unicast (s_bcast=0, s_sel<N_OUT): s_ready SHALL equal free[s_sel].
REQ-007 Broadcast (s_bcast=1): s_ready SHALL equal AND of free[0..N_OUT-1], and s_sel is ignored.
REQ-008 Out-of-range (s_bcast=0, s_sel>=N_OUT): s_ready SHALL be 1 and the beat SHALL be discarded, with no channel loaded.
REQ-009 s_ready SHALL be combinational from s_valid-independent terms only (s_sel, s_bcast, m_valid, m_ready); it SHALL NOT depend on s_valid.
REQ-010 On an accepted unicast beat, m_data[s_sel] SHALL load s_data and m_valid[s_sel] SHALL be 1 on the next cycle (latency 1).
REQ-011 On an accepted broadcast beat, every channel SHALL load s_data and assert m_valid on the next cycle.
REQ-012 A channel with m_valid && m_ready and no new load SHALL clear m_valid next cycle; m_data holds its last value.
REQ-013 A channel with simultaneous drain and load SHALL keep m_valid=1 with new data (full throughput, one beat per cycle per channel).
REQ-014 While m_valid[i]=1 && m_ready[i]=0, m_data[i] and m_valid[i] SHALL remain stable.
REQ-015 Unselected channels SHALL be unaffected by a unicast beat.
REQ-016 drop_cnt SHALL increment by 1 per discarded beat and saturate at 16'hFFFF.
REQ-017 Changing s_sel/s_bcast while s_valid=1 && s_ready=0 is permitted; acceptance uses values in the accepting cycle.

Reset
REQ-018 rst_n=0 SHALL asynchronously force m_valid=0, all m_data=0, drop_cnt=0.
REQ-019 During reset s_ready SHALL follow REQ-006..008 from the reset register values; beats presented during reset SHALL NOT load any channel or increment drop_cnt.
REQ-020 Reset mid-transfer SHALL discard all held beats; no partial state survives deassertion.
REQ-021 Reset deassertion SHALL be consumed synchronously to clk; the first load is possible on the first rising edge after release.

Structure
REQ-022 Shared package demux_pkg SHALL hold the DROP_CNT_W=16 constant and the ceil-log2 helper function used for SEL_W.
REQ-023 A sub-module demux_out_slot (one-entry valid/data register with load, drain and free) SHALL be instantiated N_OUT times via generate.
REQ-024 The top level SHALL contain only select decode, s_ready logic, broadcast AND-reduce and drop counter.

Verification
REQ-025 Reset then unicast s_sel=3, s_data=8'hA5, all m_ready=1 -> next cycle m_valid=8'b0000_1000, channel 3 data 8'hA5, then m_valid=0.
REQ-026 Backpressure: m_ready[2]=0, two beats to sel=2 (8'h11, 8'h22) -> first accepted, s_ready=0 for second until m_ready[2]=1; channel 2 data stays 8'h11 while stalled, then 8'h22.
REQ-027 Broadcast 8'h5A with m_ready[7]=0 and m_valid[7]=1 -> s_ready=0; release m_ready[7] -> all 8 channels show 8'h5A next cycle.
REQ-028 N_OUT=5, s_sel=6, three beats -> s_ready=1, no m_valid change, drop_cnt=3; saturation check from preload of 16'hFFFE -> stays 16'hFFFF.
REQ-029 Streaming: s_sel=0 every cycle, m_ready[0]=1, 16 beats 0..15 -> 16 outputs in order, one per cycle, no bubbles.
REQ-030 Assert rst_n=0 mid-stream between clock edges -> m_valid=0 immediately (asynchronous), drop_cnt=0, no output after release until a new beat.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: counter width,
// beat classification and the select-width helper.
package demux_pkg;

  // Width of the discarded-beat counter.
  localparam int DROP_CNT_W = 16;

  // How an incoming beat is routed.
  typedef enum logic [1:0] {
    KIND_UNICAST = 2'd0,  // one in-range destination channel
    KIND_BCAST   = 2'd1,  // copy to every channel
    KIND_DROP    = 2'd2   // out-of-range select, beat is discarded
  } beat_kind_e;

  // ceil(log2(n)) for n >= 2; used to size the channel select.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single-entry valid/data register that drains on
// m_ready and may be refilled in the same cycle for full throughput.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              free
);

  // The slot can take a beat when it is empty or its content leaves this cycle.
  assign free = !m_valid || m_ready;

  // Valid/data register: load wins over drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload register is reset too, so a reset channel reads back
      // as zero rather than stale data from before the reset.
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_n_stream.sv
// 1-to-N stream demultiplexer with unicast, broadcast and discard of
// out-of-range selects. Each channel owns a one-entry output slot; the top
// only decodes the select, forms s_ready and counts dropped beats.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_OUT  = 8,
  localparam int SEL_W  = clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_bcast,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  beat_kind_e                kind;
  logic       [N_OUT-1:0]    free;
  logic       [N_OUT-1:0]    load;
  logic                      sel_free;
  logic                      all_free;
  logic                      accept;
  logic       [DROP_CNT_W-1:0] drop_cnt_q;

  // Classify the presented beat from its routing fields alone.
  always_comb begin
    // NOTE: a default before any branch keeps combinational outputs from
    // inferring latches when no branch assigns them.
    kind = KIND_DROP;
    if (s_bcast) begin
      kind = KIND_BCAST;
    end else if ({1'b0, s_sel} < (SEL_W + 1)'(N_OUT)) begin
      kind = KIND_UNICAST;
    end
  end

  // Free flag of the addressed channel; out-of-range selects read as not free
  // but are never used in that case.
  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (s_sel == SEL_W'(i)) begin
        sel_free = free[i];
      end
    end
  end

  // A broadcast needs every slot able to take the beat.
  assign all_free = &free;

  // s_ready depends only on routing fields and channel state, never s_valid.
  always_comb begin
    s_ready = 1'b1;
    unique case (kind)
      KIND_UNICAST: s_ready = sel_free;
      KIND_BCAST:   s_ready = all_free;
      default:      s_ready = 1'b1;
    endcase
  end

  assign accept = s_valid && s_ready;

  // Per-channel load strobes for the accepted beat.
  always_comb begin
    load = '0;
    for (int i = 0; i < N_OUT; i++) begin
      load[i] = accept &&
                ((kind == KIND_BCAST) ||
                 ((kind == KIND_UNICAST) && (s_sel == SEL_W'(i))));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (s_data),
      .m_ready   (m_ready[g]),
      .m_valid   (m_valid[g]),
      .m_data    (m_data[g*DATA_W +: DATA_W]),
      .free      (free[g])
    );
  end

  // Saturating count of discarded beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && (kind == KIND_DROP) && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;

  // A load must only ever target a slot that can take it.
  a_load_into_free: assert property (@(posedge clk) disable iff (!rst_n)
    (load & ~free) == '0);

  // A unicast beat loads at most one channel.
  a_unicast_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (kind != KIND_BCAST) |-> $onehot0(load));

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: an 8-channel instance for the data path
// scenarios and a 5-channel instance for out-of-range drops and the counter.
module tb_demux_1_n_stream;

  logic clk;
  logic rst_n;

  // 8-channel instance
  logic        s_valid8, s_ready8, s_bcast8;
  logic [7:0]  s_data8;
  logic [2:0]  s_sel8;
  logic [7:0]  m_valid8, m_ready8;
  logic [63:0] m_data8;
  logic [15:0] drop_cnt8;

  // 5-channel instance
  logic        s_valid5, s_ready5, s_bcast5;
  logic [7:0]  s_data5;
  logic [2:0]  s_sel5;
  logic [4:0]  m_valid5, m_ready5;
  logic [39:0] m_data5;
  logic [15:0] drop_cnt5;

  int n_cmp;
  int n_fail;

  demux_1_n_stream #(.DATA_W(8), .N_OUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .s_sel(s_sel8), .s_bcast(s_bcast8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
    .drop_cnt(drop_cnt8)
  );

  demux_1_n_stream #(.DATA_W(8), .N_OUT(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .s_sel(s_sel5), .s_bcast(s_bcast5),
    .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5),
    .drop_cnt(drop_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch8(input int i);
    return m_data8[i*8 +: 8];
  endfunction

  function automatic logic [7:0] ch5(input int i);
    return m_data5[i*8 +: 8];
  endfunction

  typedef struct {
    logic       bcast;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] exp_valid;
  } vec_t;

  vec_t vecs[8];

  // Reference state for the 5-channel random run: the beat each channel is
  // expected to be holding, plus the expected discard count.
  bit         pend[5];
  logic [7:0] pend_data[5];
  int         exp_drop;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    s_valid8 = 1'b0; s_bcast8 = 1'b0; s_data8 = '0; s_sel8 = '0; m_ready8 = '1;
    s_valid5 = 1'b0; s_bcast5 = 1'b0; s_data5 = '0; s_sel5 = '0; m_ready5 = '1;

    // ---------------- reset state ----------------
    #1;
    check("rst_m_valid8", m_valid8, 0);
    check("rst_m_data8", m_data8, 0);
    check("rst_drop8", drop_cnt8, 0);
    check("rst_s_ready8", s_ready8, 1);
    check("rst_m_valid5", m_valid5, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- table: single beats, all sinks ready ----------------
    vecs[0] = '{1'b0, 3'd3, 8'hA5, 8'h08};
    vecs[1] = '{1'b0, 3'd0, 8'h01, 8'h01};
    vecs[2] = '{1'b0, 3'd7, 8'hFE, 8'h80};
    vecs[3] = '{1'b1, 3'd5, 8'h5A, 8'hFF};
    vecs[4] = '{1'b0, 3'd1, 8'h3C, 8'h02};
    vecs[5] = '{1'b0, 3'd6, 8'hC3, 8'h40};
    vecs[6] = '{1'b1, 3'd0, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 3'd2, 8'h81, 8'h04};
    for (int v = 0; v < 8; v++) begin
      m_ready8 = '1;
      s_valid8 = 1'b1;
      s_bcast8 = vecs[v].bcast;
      s_sel8   = vecs[v].sel;
      s_data8  = vecs[v].data;
      #1;
      check("tbl_s_ready", s_ready8, 1);
      tick();
      s_valid8 = 1'b0;
      check("tbl_m_valid", m_valid8, vecs[v].exp_valid);
      for (int i = 0; i < 8; i++) begin
        if (vecs[v].exp_valid[i]) check("tbl_m_data", ch8(i), vecs[v].data);
      end
      tick();
      check("tbl_drain", m_valid8, 0);
    end
    s_bcast8 = 1'b0;

    // ---------------- backpressure on channel 2 ----------------
    m_ready8 = 8'hFB;
    s_valid8 = 1'b1; s_sel8 = 3'd2; s_data8 = 8'h11;
    #1;
    check("bp_ready_first", s_ready8, 1);
    tick();
    s_data8 = 8'h22;
    #1;
    check("bp_ready_stall", s_ready8, 0);
    check("bp_valid_stall", m_valid8, 8'h04);
    check("bp_data_stall", ch8(2), 8'h11);
    tick();
    check("bp_ready_stall2", s_ready8, 0);
    check("bp_data_stall2", ch8(2), 8'h11);
    m_ready8 = 8'hFF;
    #1;
    check("bp_ready_release", s_ready8, 1);
    tick();
    s_valid8 = 1'b0;
    check("bp_valid_second", m_valid8, 8'h04);
    check("bp_data_second", ch8(2), 8'h22);
    tick();
    check("bp_drain", m_valid8, 0);

    // ---------------- broadcast blocked by channel 7 ----------------
    m_ready8 = 8'h7F;
    s_valid8 = 1'b1; s_sel8 = 3'd7; s_data8 = 8'h77;
    tick();
    check("bc_pre_valid", m_valid8, 8'h80);
    s_bcast8 = 1'b1; s_sel8 = 3'd1; s_data8 = 8'h5A;
    #1;
    check("bc_ready_blocked", s_ready8, 0);
    tick();
    check("bc_valid_blocked", m_valid8, 8'h80);
    check("bc_data7_blocked", ch8(7), 8'h77);
    m_ready8 = 8'hFF;
    #1;
    check("bc_ready_release", s_ready8, 1);
    tick();
    s_valid8 = 1'b0; s_bcast8 = 1'b0;
    check("bc_valid_all", m_valid8, 8'hFF);
    for (int i = 0; i < 8; i++) check("bc_data_all", ch8(i), 8'h5A);
    tick();
    check("bc_drain", m_valid8, 0);

    // ---------------- streaming on channel 0 ----------------
    m_ready8 = 8'hFF;
    s_valid8 = 1'b1; s_sel8 = 3'd0;
    for (int k = 0; k < 16; k++) begin
      s_data8 = 8'(k);
      #1;
      check("st_ready", s_ready8, 1);
      tick();
      check("st_valid", m_valid8, 8'h01);
      check("st_data", ch8(0), 8'(k));
    end
    s_valid8 = 1'b0;
    tick();
    check("st_drain", m_valid8, 0);

    // ---------------- out-of-range drops on the 5-channel instance -------
    m_ready5 = '1;
    s_valid5 = 1'b1; s_sel5 = 3'd6; s_data5 = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drop_ready", s_ready5, 1);
      tick();
      check("drop_no_valid", m_valid5, 0);
    end
    s_valid5 = 1'b0;
    check("drop_cnt3", drop_cnt5, 3);

    // ---------------- randomized traffic on the 5-channel instance -------
    exp_drop = 3;
    for (int i = 0; i < 5; i++) begin
      pend[i] = 1'b0;
      pend_data[i] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [4:0] exp_valid;
      logic [4:0] chan_free;
      logic       exp_ready;
      m_ready5 = 5'($urandom);
      s_valid5 = ($urandom_range(0, 3) != 0);
      s_bcast5 = ($urandom_range(0, 7) == 0);
      s_sel5   = 3'($urandom_range(0, 7));
      s_data5  = 8'($urandom);
      #1;
      for (int i = 0; i < 5; i++) begin
        exp_valid[i] = pend[i];
        chan_free[i] = !pend[i] || m_ready5[i];
      end
      if (s_bcast5)        exp_ready = &chan_free;
      else if (s_sel5 < 5) exp_ready = chan_free[s_sel5];
      else                 exp_ready = 1'b1;
      check("rnd_m_valid", m_valid5, exp_valid);
      for (int i = 0; i < 5; i++) begin
        if (pend[i]) check("rnd_m_data", ch5(i), pend_data[i]);
      end
      check("rnd_s_ready", s_ready5, exp_ready);
      check("rnd_drop_cnt", drop_cnt5, 16'(exp_drop));
      for (int i = 0; i < 5; i++) begin
        if (pend[i] && m_ready5[i]) pend[i] = 1'b0;
      end
      if (s_valid5 && exp_ready) begin
        if (s_bcast5) begin
          for (int i = 0; i < 5; i++) begin
            pend[i] = 1'b1;
            pend_data[i] = s_data5;
          end
        end else if (s_sel5 < 5) begin
          pend[s_sel5] = 1'b1;
          pend_data[s_sel5] = s_data5;
        end else begin
          exp_drop++;
        end
      end
      tick();
    end
    s_valid5 = 1'b0; m_ready5 = '1;
    tick();
    check("rnd_drain", m_valid5, 0);
    check("rnd_drop_final", drop_cnt5, 16'(exp_drop));

    // ---------------- asynchronous reset mid-stream ----------------
    m_ready8 = 8'hFF;
    s_valid8 = 1'b1; s_sel8 = 3'd4;
    for (int k = 0; k < 3; k++) begin
      s_data8 = 8'h90 + 8'(k);
      tick();
    end
    check("ar_pre_valid", m_valid8, 8'h10);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid_async", m_valid8, 0);
    check("ar_data_async", m_data8, 0);
    check("ar_drop5_async", drop_cnt5, 0);
    check("ar_ready_in_reset", s_ready8, 1);
    s_valid5 = 1'b1; s_sel5 = 3'd6;
    tick();
    tick();
    check("ar_no_load_in_reset", m_valid8, 0);
    check("ar_no_drop_in_reset", drop_cnt5, 0);
    rst_n = 1'b1;
    s_valid8 = 1'b0; s_valid5 = 1'b0;
    tick();
    check("ar_no_output_after", m_valid8, 0);
    check("ar_drop5_after", drop_cnt5, 0);
    // Short reset, released between edges with a beat waiting.
    rst_n = 1'b0;
    #2;
    s_valid8 = 1'b1; s_sel8 = 3'd1; s_data8 = 8'h42;
    rst_n = 1'b1;
    tick();
    s_valid8 = 1'b0;
    check("ar_first_load_valid", m_valid8, 8'h02);
    check("ar_first_load_data", ch8(1), 8'h42);
    tick();
    check("ar_first_load_drain", m_valid8, 0);

    // ---------------- drop counter saturation ----------------
    m_ready5 = '1;
    s_valid5 = 1'b1; s_bcast5 = 1'b0; s_sel5 = 3'd6;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", drop_cnt5, 16'hFFFE);
    tick();
    check("sat_ffff", drop_cnt5, 16'hFFFF);
    check("sat_ready", s_ready5, 1);
    tick();
    tick();
    check("sat_hold", drop_cnt5, 16'hFFFF);
    check("sat_no_valid", m_valid5, 0);
    s_valid5 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
